// File: rtl/datapath_unit.sv
// datapath_unit: register file + ALU/shifter; writeback is registered and committed one cycle later (optional forwarding under DATAPATH_FWD_EN)
module datapath_unit #(
  parameter int DW = 8,
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(DW)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cen_i,
  input  logic          valid_i,
  input  logic          we_i,
  input  logic          flag_we_i,
  input  logic          op2_sel_i,
  input  logic          shift_i,
  input  logic [2:0]    func_i,
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rd_i,
  input  logic [DW-1:0] immed_i,
  input  logic [CW-1:0] count_i,
  input  logic [1:0]    wsel_i,
  input  logic [DW-1:0] mem_dat_i,
  input  logic [DW-1:0] port_dat_i,
  output logic [DW-1:0] rs_dat_o,
  output logic [DW-1:0] rs2_dat_o,
  output logic [DW-1:0] result_o,
  output logic          result_valid_o,
  output logic          carry_o,
  output logic          zero_o
);
`ifdef DATAPATH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic [DW-1:0] regs [NREG];
  logic pend_we;
  logic [AW-1:0] pend_rd;
  logic [DW-1:0] op2, alu_res, sh_res, res, wb;
  logic alu_c, sh_c, res_c, cin;
  logic [DW:0] sum, diff;
  logic [2*DW-1:0] shl_w, shr_w;
  assign rs_dat_o = rs_i == '0 ? '0 : (FWD && pend_we && rs_i == pend_rd) ? result_o : regs[rs_i];
  assign rs2_dat_o = rs2_i == '0 ? '0 : (FWD && pend_we && rs2_i == pend_rd) ? result_o : regs[rs2_i];
  assign op2 = op2_sel_i ? immed_i : rs2_dat_o;
  assign cin = func_i[0] & carry_o;
  assign sum = {1'b0, rs_dat_o} + {1'b0, op2} + {{DW{1'b0}}, cin};
  assign diff = {1'b0, rs_dat_o} - {1'b0, op2} - {{DW{1'b0}}, cin};
  // Shifting through a double-width word leaves the last bit shifted out at the seam.
  assign shl_w = {{DW{1'b0}}, rs_dat_o} << count_i;
  assign shr_w = {rs_dat_o, {DW{1'b0}}} >> count_i;
  always_comb begin
    alu_res = func_i[2] ? (func_i[1] ? (func_i[0] ? rs_dat_o & ~op2 : rs_dat_o ^ op2)
                                     : (func_i[0] ? rs_dat_o | op2 : rs_dat_o & op2))
                        : (func_i[1] ? diff[DW-1:0] : sum[DW-1:0]);
    alu_c = !func_i[2] && (func_i[1] ? diff[DW] : sum[DW]);
    sh_res = func_i[1] ? (func_i[0] ? shr_w[2*DW-1:DW] | shr_w[DW-1:0] : shl_w[DW-1:0] | shl_w[2*DW-1:DW])
                       : (func_i[0] ? shr_w[2*DW-1:DW] : shl_w[DW-1:0]);
    sh_c = func_i[0] ? shr_w[DW-1] : shl_w[DW];
    res = shift_i ? sh_res : alu_res;
    res_c = shift_i ? sh_c : alu_c;
    wb = wsel_i == 2'b01 ? mem_dat_i : wsel_i == 2'b10 ? port_dat_i : res;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      result_o <= '0;
      result_valid_o <= 1'b0;
      carry_o <= 1'b0;
      zero_o <= 1'b0;
      pend_we <= 1'b0;
      pend_rd <= '0;
    end else if (cen_i) begin
      if (pend_we && pend_rd != '0) regs[pend_rd] <= result_o;
      result_valid_o <= valid_i;
      pend_we <= valid_i & we_i;
      if (valid_i) begin
        result_o <= wb;
        pend_rd <= rd_i;
        if (flag_we_i) begin
          carry_o <= res_c;
          zero_o <= res == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: table-driven scoreboard bench for datapath_unit (DW=8, NREG=8)
module tb_datapath_unit;
  logic clk = 0, rst_i = 1, cen_i = 1, valid_i = 0, we_i = 0, flag_we_i = 0, op2_sel_i = 0, shift_i = 0;
  logic [2:0] func_i = 0, rs_i = 0, rs2_i = 0, rd_i = 0, count_i = 0;
  logic [7:0] immed_i = 0, mem_dat_i = 8'h5A, port_dat_i = 8'hC3;
  logic [1:0] wsel_i = 0;
  logic [7:0] rs_dat_o, rs2_dat_o, result_o;
  logic result_valid_o, carry_o, zero_o;
  int nchk = 0, nerr = 0;
  typedef struct {
    logic v, we, fwe, op2, sh;
    logic [2:0] fn, rs, rs2, rd;
    logic [7:0] imm;
    logic [2:0] cnt;
    logic [1:0] ws;
    logic [7:0] er;
    logic ec, ez;
  } vec_t;
  typedef struct {
    logic [7:0] r;
    logic v, c, z;
  } exp_t;
  vec_t tbl [20];
  exp_t q [$];
  exp_t e;
  datapath_unit #(.DW(8), .NREG(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .cen_i(cen_i), .valid_i(valid_i), .we_i(we_i),
    .flag_we_i(flag_we_i), .op2_sel_i(op2_sel_i), .shift_i(shift_i), .func_i(func_i),
    .rs_i(rs_i), .rs2_i(rs2_i), .rd_i(rd_i), .immed_i(immed_i), .count_i(count_i),
    .wsel_i(wsel_i), .mem_dat_i(mem_dat_i), .port_dat_i(port_dat_i),
    .rs_dat_o(rs_dat_o), .rs2_dat_o(rs2_dat_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .carry_o(carry_o), .zero_o(zero_o)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, we, fwe, op2, sh, logic [2:0] fn, rs, rs2, rd,
                              logic [7:0] imm, logic [2:0] cnt, logic [1:0] ws,
                              logic [7:0] er, logic ec, ez);
    mk = '{v, we, fwe, op2, sh, fn, rs, rs2, rd, imm, cnt, ws, er, ec, ez};
  endfunction
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask
  task automatic drv(input logic v, we, fwe, op2, sh, input logic [2:0] fn, rs, rs2, rd,
                     input logic [7:0] imm, input logic [2:0] cnt, input logic [1:0] ws);
    valid_i = v; we_i = we; flag_we_i = fwe; op2_sel_i = op2; shift_i = sh; func_i = fn;
    rs_i = rs; rs2_i = rs2; rd_i = rd; immed_i = imm; count_i = cnt; wsel_i = ws;
  endtask
  task automatic idle();
    valid_i = 0; we_i = 0; flag_we_i = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = mk(1,1,1,1,0,0,0,0,1,8'hFF,0,0, 8'hFF,0,0);
    tbl[1]  = mk(1,1,1,1,0,0,0,0,2,8'h01,0,0, 8'h01,0,0);
    tbl[2]  = mk(1,1,1,1,0,0,1,0,3,8'h01,0,0, 8'h00,1,1);
    tbl[3]  = mk(1,1,1,1,0,1,0,0,4,8'h10,0,0, 8'h11,0,0);
    tbl[4]  = mk(1,1,1,0,0,2,1,2,5,8'h00,0,0, 8'hFE,0,0);
    tbl[5]  = mk(1,1,1,0,0,2,2,1,6,8'h00,0,0, 8'h02,1,0);
    tbl[6]  = mk(1,1,1,1,0,3,1,0,7,8'h0F,0,0, 8'hEF,0,0);
    tbl[7]  = mk(1,0,1,1,0,4,5,0,1,8'h0F,0,0, 8'h0E,0,0);
    tbl[8]  = mk(1,0,1,1,0,5,4,0,1,8'h80,0,0, 8'h91,0,0);
    tbl[9]  = mk(1,0,1,0,0,6,1,1,1,8'h00,0,0, 8'h00,0,1);
    tbl[10] = mk(1,0,1,1,0,7,1,0,1,8'h0F,0,0, 8'hF0,0,0);
    tbl[11] = mk(1,0,1,0,1,0,4,0,1,8'h00,4,0, 8'h10,1,0);
    tbl[12] = mk(1,0,1,0,1,1,4,0,1,8'h00,1,0, 8'h08,1,0);
    tbl[13] = mk(1,0,1,0,1,2,5,0,1,8'h00,1,0, 8'hFD,1,0);
    tbl[14] = mk(1,0,1,0,1,3,2,0,1,8'h00,2,0, 8'h40,0,0);
    tbl[15] = mk(1,0,1,0,1,1,2,0,1,8'h00,1,0, 8'h00,1,1);
    tbl[16] = mk(1,1,0,1,0,0,0,0,6,8'h00,0,1, 8'h5A,1,1);
    tbl[17] = mk(1,1,0,1,0,0,0,0,7,8'h00,0,2, 8'hC3,1,1);
    tbl[18] = mk(1,0,0,1,0,0,0,0,1,8'h22,0,3, 8'h22,1,1);
    tbl[19] = mk(0,1,1,1,0,0,0,0,1,8'h99,0,0, 8'h22,1,1);
    rs_i = 1;
    #12;
    chk("rst_result", result_o, 8'h00);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_r1", rs_dat_o, 8'h00);
    @(negedge clk); rst_i = 0;
    @(negedge clk); drv(1,1,0,1,0,0,0,0,1,8'h05,0,0);
    tick();
    chk("first_result", result_o, 8'h05);
    chk("first_valid", result_valid_o, 1);
    @(negedge clk); idle(); rs_i = 1;
    tick();
    chk("first_r1", rs_dat_o, 8'h05);
    chk("idle_valid", result_valid_o, 0);
    chk("idle_hold", result_o, 8'h05);
    @(negedge clk); drv(1,1,0,1,0,0,0,0,2,8'h10,0,0);
    tick();
    idle(); rs_i = 2;
    #1;
`ifdef DATAPATH_FWD_EN
    chk("fwd_r2", rs_dat_o, 8'h10);
`else
    chk("nofwd_r2", rs_dat_o, 8'h00);
`endif
    tick();
    chk("commit_r2", rs_dat_o, 8'h10);
    @(negedge clk); drv(1,1,0,1,0,0,0,0,0,8'hAA,0,0);
    tick();
    chk("r0_result", result_o, 8'hAA);
    @(negedge clk); idle(); rs_i = 0;
    tick();
    chk("r0_read", rs_dat_o, 8'h00);
    @(negedge clk); drv(1,1,0,1,0,0,0,0,4,8'h81,0,0);
    tick();
    @(negedge clk); idle();
    tick();
    @(negedge clk); drv(1,0,1,0,1,3,4,0,1,8'h00,1,0);
    tick();
    chk("ror_result", result_o, 8'hC0);
    chk("ror_carry", carry_o, 1);
    @(negedge clk); drv(1,0,1,0,1,0,4,0,1,8'h00,0,0);
    tick();
    chk("shl0_result", result_o, 8'h81);
    chk("shl0_carry", carry_o, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drv(tbl[i].v, tbl[i].we, tbl[i].fwe, tbl[i].op2, tbl[i].sh, tbl[i].fn, tbl[i].rs,
          tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].cnt, tbl[i].ws);
      q.push_back('{tbl[i].er, tbl[i].v, tbl[i].ec, tbl[i].ez});
      tick();
      e = q.pop_front();
      chk($sformatf("v%0d_result", i), result_o, e.r);
      chk($sformatf("v%0d_valid", i), result_valid_o, e.v);
      chk($sformatf("v%0d_carry", i), carry_o, e.c);
      chk($sformatf("v%0d_zero", i), zero_o, e.z);
    end
    @(negedge clk); idle();
    tick();
    rs_i = 6; rs2_i = 7; #1;
    chk("tbl_r6", rs_dat_o, 8'h5A);
    chk("tbl_r7", rs2_dat_o, 8'hC3);
    rs_i = 1; rs2_i = 5; #1;
    chk("tbl_r1", rs_dat_o, 8'hFF);
    chk("tbl_r5", rs2_dat_o, 8'hFE);
    @(negedge clk); drv(1,1,0,1,0,0,0,0,3,8'h44,0,0);
    tick();
    @(negedge clk); cen_i = 0; drv(1,1,1,1,0,0,0,0,4,8'h77,0,0); rs_i = 3;
    tick();
    tick();
    chk("cen_result", result_o, 8'h44);
    chk("cen_valid", result_valid_o, 1);
    chk("cen_carry", carry_o, 1);
`ifdef DATAPATH_FWD_EN
    chk("cen_r3", rs_dat_o, 8'h44);
`else
    chk("cen_r3", rs_dat_o, 8'h00);
`endif
    @(negedge clk); cen_i = 1; idle(); rs_i = 3;
    tick();
    chk("cen_commit_r3", rs_dat_o, 8'h44);
    chk("cen_rel_valid", result_valid_o, 0);
    @(negedge clk); drv(1,1,1,1,0,0,0,0,5,8'h33,0,0);
    tick();
    @(negedge clk); idle(); rst_i = 1; rs_i = 5;
    #1;
    chk("async_rst_result", result_o, 8'h00);
    tick();
    @(negedge clk); rst_i = 0;
    tick();
    tick();
    chk("post_rst_r5", rs_dat_o, 8'h00);
    chk("post_rst_result", result_o, 8'h00);
    chk("post_rst_valid", result_valid_o, 0);
    chk("post_rst_carry", carry_o, 0);
    chk("post_rst_zero", zero_o, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
